// File: rtl/slot_alloc_ctrl_if.sv
// slot_alloc_ctrl_if
//   Allocation/release bus between requesting engines (master) and the slot
//   allocation controller (slave).
//   alloc_req/alloc_gnt/alloc_idx : allocation request and registered grant
//   free_vld/free_idx/free_err    : release request and illegal-release pulse
//   flush                         : synchronous release of every slot
//   used_cnt/full/empty           : occupancy status
interface slot_alloc_ctrl_if #(
  parameter int IDX_W = 5
) ();
  logic             alloc_req;
  logic             alloc_gnt;
  logic [IDX_W-1:0] alloc_idx;
  logic             free_vld;
  logic [IDX_W-1:0] free_idx;
  logic             flush;
  logic             free_err;
  logic [IDX_W:0]   used_cnt;
  logic             full;
  logic             empty;

  modport master (
    output alloc_req, free_vld, free_idx, flush,
    input  alloc_gnt, alloc_idx, free_err, used_cnt, full, empty
  );

  modport slave (
    input  alloc_req, free_vld, free_idx, flush,
    output alloc_gnt, alloc_idx, free_err, used_cnt, full, empty
  );
endinterface

// File: rtl/slot_alloc_ctrl.sv
// slot_alloc_ctrl
//   Owns occupancy of NUM_SLOTS memory slots. One allocation and one release
//   per cycle; an allocation grants the lowest-numbered free slot.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : slot_alloc_ctrl_if.slave (request/grant, release/error, status)
module slot_alloc_ctrl #(
  parameter int NUM_SLOTS = 32,
  parameter int IDX_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  slot_alloc_ctrl_if.slave  bus
);

  logic [NUM_SLOTS-1:0] r_busy;
  logic [IDX_W:0]       r_used;
  logic                 r_gnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_err;

  logic                 w_full;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_alloc;
  logic [NUM_SLOTS-1:0] w_hit;
  logic                 w_free_ok;
  logic                 w_free_bad;
  logic [NUM_SLOTS-1:0] w_set;
  logic [NUM_SLOTS-1:0] w_clr;

  assign w_full = (r_used == (IDX_W+1)'(NUM_SLOTS));

  // Lowest free slot; scan downward so the last assignment wins with the
  // lowest index. Only meaningful while not full.
  always_comb begin
    w_cand = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--)
      if (!r_busy[i]) w_cand = IDX_W'(i);
  end

  // Busy bit of the addressed slot; an out-of-range index matches nothing,
  // so it reads as "not busy" and is reported like a double-free.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      w_hit[i] = r_busy[i] && (bus.free_idx == IDX_W'(i));
  end

  assign w_alloc    = bus.alloc_req && !w_full && !bus.flush;
  assign w_free_ok  = bus.free_vld && !bus.flush && (|w_hit);
  assign w_free_bad = bus.free_vld && !bus.flush && !(|w_hit);

  // Set and clear never collide: the candidate is free, a legal release is busy.
  always_comb begin
    w_set = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      w_set[i] = w_alloc && (w_cand == IDX_W'(i));
  end
  assign w_clr = w_free_ok ? w_hit : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_used <= '0;
      r_gnt  <= 1'b0;
      r_idx  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_gnt <= w_alloc;
      r_err <= w_free_bad;
      if (w_alloc) r_idx <= w_cand;
      if (bus.flush) begin
        r_busy <= '0;
        r_used <= '0;
      end else begin
        r_busy <= (r_busy | w_set) & ~w_clr;
        r_used <= r_used + (IDX_W+1)'(w_alloc) - (IDX_W+1)'(w_free_ok);
      end
    end
  end

  assign bus.alloc_gnt = r_gnt;
  assign bus.alloc_idx = r_idx;
  assign bus.free_err  = r_err;
  assign bus.used_cnt  = r_used;
  assign bus.full      = w_full;
  assign bus.empty     = (r_used == '0);

endmodule

// File: tb/tb_slot_alloc_ctrl.sv
// tb_slot_alloc_ctrl
//   Directed and random stimulus for slot_alloc_ctrl (32 slots) against a
//   set-of-slots reference model, plus a 20-slot instance for out-of-range
//   release handling.
module tb_slot_alloc_ctrl;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slot_alloc_ctrl_if #(.IDX_W(5)) bus0 ();
  slot_alloc_ctrl_if #(.IDX_W(5)) bus1 ();

  slot_alloc_ctrl #(.NUM_SLOTS(32), .IDX_W(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  slot_alloc_ctrl #(.NUM_SLOTS(20), .IDX_W(5)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int failures = 0;

  // Reference model: which slots are owned, plus last granted index.
  bit mbusy [N];
  bit exp_gnt, exp_err;
  int exp_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    exp_gnt = 1'b0; exp_err = 1'b0; exp_idx = 0;
  endtask

  task automatic check_all(input string tag);
    int c;
    c = mcount();
    chk({tag, ".gnt"},  bus0.alloc_gnt, exp_gnt);
    chk({tag, ".idx"},  bus0.alloc_idx, exp_idx);
    chk({tag, ".err"},  bus0.free_err,  exp_err);
    chk({tag, ".used"}, bus0.used_cnt,  c);
    chk({tag, ".full"}, bus0.full,  c == N);
    chk({tag, ".empty"}, bus0.empty, c == 0);
  endtask

  // One clock: drive inputs, advance model from pre-edge state, check after edge.
  task automatic cyc(input bit req, input bit fv, input int fi, input bit fl, input string tag);
    int  c, cand;
    bit  ok;
    bus0.alloc_req = req; bus0.free_vld = fv; bus0.free_idx = 5'(fi); bus0.flush = fl;
    c = mcount();
    cand = -1;
    for (int i = N-1; i >= 0; i--) if (!mbusy[i]) cand = i;
    ok = fv && fi < N && mbusy[fi];
    if (fl) begin
      for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
      exp_gnt = 1'b0; exp_err = 1'b0;
    end else begin
      exp_gnt = req && c < N;
      exp_err = fv && !ok;
      if (exp_gnt) begin mbusy[cand] = 1'b1; exp_idx = cand; end
      if (ok) mbusy[fi] = 1'b0;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    int gcount;
    bus0.alloc_req = 0; bus0.free_vld = 0; bus0.free_idx = '0; bus0.flush = 0;
    bus1.alloc_req = 0; bus1.free_vld = 0; bus1.free_idx = '0; bus1.flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset_rel");

    // Fill: 32 ascending grants, none on the 33rd cycle.
    gcount = 0;
    for (int k = 0; k < 33; k++) begin
      cyc(1, 0, 0, 0, "fill");
      if (bus0.alloc_gnt) gcount++;
      if (k < 32) chk("fill.asc_idx", bus0.alloc_idx, k);
    end
    chk("fill.gnt_count", gcount, 32);
    chk("fill.full", bus0.full, 1);
    chk("fill.used32", bus0.used_cnt, 32);

    // Free 5 and 17, then regrant in that order.
    cyc(0, 1, 5, 0, "free5");
    cyc(0, 1, 17, 0, "free17");
    cyc(1, 0, 0, 0, "regrant1");
    chk("regrant1.idx5", bus0.alloc_idx, 5);
    cyc(1, 0, 0, 0, "regrant2");
    chk("regrant2.idx17", bus0.alloc_idx, 17);
    chk("regrant.used32", bus0.used_cnt, 32);

    // Full with request held; release 9 and expect it granted one cycle later.
    cyc(1, 1, 9, 0, "full_free9");
    chk("full_free9.nognt", bus0.alloc_gnt, 0);
    chk("full_free9.used31", bus0.used_cnt, 31);
    cyc(1, 0, 0, 0, "full_gnt9");
    chk("full_gnt9.gnt", bus0.alloc_gnt, 1);
    chk("full_gnt9.idx9", bus0.alloc_idx, 9);
    chk("full_gnt9.used32", bus0.used_cnt, 32);
    cyc(0, 0, 0, 0, "idle");

    // Double-free of slot 3.
    cyc(0, 1, 3, 0, "free3");
    cyc(0, 1, 3, 0, "dfree3");
    chk("dfree3.err", bus0.free_err, 1);
    chk("dfree3.used31", bus0.used_cnt, 31);
    cyc(0, 0, 0, 0, "dfree3_after");
    chk("dfree3.err_pulse", bus0.free_err, 0);

    // Release the current candidate while allocating: error, allocation proceeds.
    cyc(1, 1, 3, 0, "cand_dfree");
    chk("cand_dfree.err", bus0.free_err, 1);
    chk("cand_dfree.idx3", bus0.alloc_idx, 3);

    // Flush drops a simultaneous alloc and free.
    cyc(0, 0, 0, 1, "flush0");
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0, "fill10");
    cyc(1, 1, 2, 1, "flush");
    chk("flush.nognt", bus0.alloc_gnt, 0);
    chk("flush.noerr", bus0.free_err, 0);
    chk("flush.used0", bus0.used_cnt, 0);
    chk("flush.empty", bus0.empty, 1);
    cyc(1, 0, 0, 0, "post_flush");
    chk("post_flush.idx0", bus0.alloc_idx, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bit r, f, fl;
      r  = ($urandom_range(0, 99) < 60);
      f  = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 2);
      cyc(r, f, int'($urandom_range(0, N-1)), fl, "rand");
    end

    // Asynchronous reset between edges.
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst_n = 1'b1;
    cyc(1, 0, 0, 0, "post_rst");
    chk("post_rst.idx0", bus0.alloc_idx, 0);
    chk("post_rst.gnt", bus0.alloc_gnt, 1);
    cyc(0, 0, 0, 0, "post_rst_idle");

    // 20-slot instance: index 31 and 19 (free) are illegal releases.
    bus1.free_vld = 1; bus1.free_idx = 5'd31;
    @(posedge clk); #1;
    chk("n20.free31.err", bus1.free_err, 1);
    chk("n20.free31.used", bus1.used_cnt, 0);
    bus1.free_idx = 5'd19;
    @(posedge clk); #1;
    chk("n20.free19.err", bus1.free_err, 1);
    bus1.free_vld = 0; bus1.alloc_req = 1;
    @(posedge clk); #1;
    chk("n20.alloc.err", bus1.free_err, 0);
    chk("n20.alloc.gnt", bus1.alloc_gnt, 1);
    chk("n20.alloc.idx", bus1.alloc_idx, 0);
    chk("n20.alloc.used", bus1.used_cnt, 1);
    bus1.alloc_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/slot_alloc_ctrl.md
# slot_alloc_ctrl

Allocation controller for a bank of up to 32 memory slots. Keeps a busy bitmap and serves one allocation and one release per cycle. Each allocation grants the lowest-numbered free slot, found by a lowest-set-bit priority encode of the inverted bitmap. The block sits between requesting engines and the slot-indexed memory, and is the single owner of slot occupancy.

## Interface
- NUM_SLOTS, 32, number of managed slots; legal range 2..32; slot indices at or above NUM_SLOTS never exist.
- IDX_W, 5, width of a slot index; must be at least clog2(NUM_SLOTS).
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_req  in  1  request one slot this cycle; level-sensitive.
- alloc_gnt  out  1  registered, one-cycle pulse; the slot in alloc_idx is now owned by the requester.
- alloc_idx  out  IDX_W  granted slot index; valid when alloc_gnt=1, holds its last value otherwise.
- free_vld  in  1  release a slot this cycle.
- free_idx  in  IDX_W  slot to release; sampled when free_vld=1.
- flush  in  1  synchronous release of all slots.
- free_err  out  1  registered, one-cycle pulse for an illegal release.
- used_cnt  out  IDX_W+1  number of busy slots.
- full  out  1  used_cnt==NUM_SLOTS.
- empty  out  1  used_cnt==0.

## Operation
- State: busy[NUM_SLOTS-1:0] and used_cnt. busy is 0 after reset.
- Reset values: alloc_gnt=0, alloc_idx=0, free_err=0, used_cnt=0, full=0, empty=1.
- full and empty are decoded from the registered used_cnt.
- Candidate slot is the lowest index i < NUM_SLOTS with busy[i]=0. It is computed from the current register value only.
- Allocate: when alloc_req=1, full=0 and flush=0:
  - set busy[candidate];
  - next cycle alloc_gnt=1 and alloc_idx=candidate.
- If alloc_req=1 while full=1: no grant, no error, and the request stays pending while held. There is no internal queue.
- Release: when free_vld=1 and flush=0:
  - if free_idx<NUM_SLOTS and busy[free_idx]=1, clear the bit;
  - otherwise change nothing and pulse free_err next cycle. This covers out-of-range and double-free.
- Allocate and release in the same cycle:
  - both are applied;
  - the released slot cannot be the candidate that cycle, because the candidate comes from pre-update state;
  - used_cnt is unchanged (+1-1).
- If full=1 and a release happens in the same cycle, the pending request is granted no earlier than the next cycle, and it gets the freed slot.
- Releasing the slot that is the current candidate is a double-free: free_err pulses and the allocation still proceeds.
- Flush has top priority:
  - busy and used_cnt clear to 0;
  - any alloc or free in that cycle is dropped, with no grant and no free_err.
- used_cnt changes by +1 per granted allocation, −1 per legal release, and is cleared by flush. It never leaves 0..NUM_SLOTS.
- Asserting rst_n low at any point returns all outputs to their reset values immediately. Nothing in flight survives.

## Timing
- Allocation latency: request at edge N, alloc_gnt at N+1. Sustained rate is 1 grant/cycle while not full.
- full, empty and used_cnt reflect every update from edge N by N+1, the same cycle as the grant pulse.
- A release at edge N makes the slot allocatable from edge N+1 onward. The earliest grant for it appears at N+2.
- free_err appears at N+1 for an illegal release at N.
- Back-to-back requests with alloc_req held high get ascending free indices, one per cycle.

## Test plan
- Reset, hold alloc_req for 33 cycles:
  - alloc_idx goes 0..31 on 32 consecutive gnt pulses;
  - full=1 and used_cnt=32 after the 32nd;
  - no gnt on the 33rd cycle.
- Start from full. Free slots 5 and 17 in separate cycles, then request twice: grants give 5 then 17, used_cnt returns to 32.
- While full with alloc_req held, free slot 9: no grant in the free cycle, grant idx 9 on the second edge after the free. used_cnt is 31 for one cycle, then back to 32.
- Free slot 3 while it is already free: free_err pulses one cycle, busy and used_cnt are unchanged. Repeat with free_idx=31 at NUM_SLOTS=20: free_err pulses.
- With 10 slots busy, assert flush together with alloc_req and free_vld: no gnt, no free_err, used_cnt=0 and empty=1 next cycle. A following alloc returns idx 0.
- Mid-stream, drop rst_n asynchronously between edges: outputs reach reset values before the next edge. After release, the first grant is idx 0.
